// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sharing of a single-port register file with locked sequences and a lock watchdog.
// RFARB_WRPRIO_EN: when defined, pending writes beat reads while unlocked.
module regfile_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int LOCK_MAX = 15,
  localparam int IW = $clog2(NREQ)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ-1:0] req_wr,
  input  logic [NREQ-1:0] req_lock,
  input  logic [NREQ*AW-1:0] req_ra1,
  input  logic [NREQ*AW-1:0] req_ra2,
  input  logic [NREQ*AW-1:0] req_wa,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic rf_wr,
  output logic [AW-1:0] rf_R1,
  output logic [AW-1:0] rf_R2,
  output logic [AW-1:0] rf_Rw,
  output logic [DW-1:0] rf_Din,
  input  logic [DW-1:0] rf_OUT1,
  input  logic [DW-1:0] rf_OUT2,
  output logic rsp_valid,
  output logic [IW-1:0] rsp_id,
  output logic [DW-1:0] rsp_d1,
  output logic [DW-1:0] rsp_d2,
  output logic lock_abort
);
  typedef enum logic {FREE, LOCKED} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, g, j;
  logic [7:0] cnt;
  logic [NREQ-1:0] elig;
  logic gv, g_wr, g_rd, g_wv;
  logic [AW-1:0] g_wa;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction
  always_comb begin
    elig = (state == LOCKED) ? req_valid & (NREQ'(1) << owner) : req_valid;
`ifdef RFARB_WRPRIO_EN
    if (state == FREE && |(req_valid & req_wr)) elig = req_valid & req_wr;
`endif
    if (!rst_n) elig = '0;
  end
  always_comb begin
    gv = 1'b0;
    g = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k >= NREQ) ? IW'(int'(ptr) + k - NREQ) : IW'(int'(ptr) + k);
      if (!gv && elig[j]) begin
        gv = 1'b1;
        g = j;
      end
    end
  end
  assign g_wr = req_wr[g];
  assign g_wv = gv & g_wr;
  assign g_rd = gv & ~g_wr;
  assign g_wa = req_wa[g*AW +: AW];
  assign req_ready = gv ? NREQ'(1) << g : '0;
  // writes to r0 are accepted but never reach the register file
  assign rf_wr = g_wv & (g_wa != '0);
  assign rf_Rw = g_wv ? g_wa : '0;
  assign rf_Din = g_wv ? req_wdata[g*DW +: DW] : '0;
  assign rf_R1 = g_rd ? req_ra1[g*AW +: AW] : '0;
  assign rf_R2 = g_rd ? req_ra2[g*AW +: AW] : '0;
  assign rsp_d1 = rf_OUT1;
  assign rsp_d2 = rf_OUT2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FREE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      lock_abort <= 1'b0;
    end else begin
      rsp_valid <= g_rd;
      if (g_rd) rsp_id <= g;
      lock_abort <= 1'b0;
      if (state == FREE) begin
        if (gv) begin
          ptr <= inc(g);
          if (req_lock[g]) begin
            state <= LOCKED;
            owner <= g;
            cnt <= '0;
          end
        end
      end else if (gv) begin
        cnt <= '0;
        if (!req_lock[g]) state <= FREE;
      end else if (cnt == 8'(LOCK_MAX - 1)) begin
        state <= FREE;
        lock_abort <= 1'b1;
        ptr <= inc(owner);
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed bench with a transaction-level model of arbitration and register contents.
module tb_regfile_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] req_valid = '0, req_wr = '0, req_lock = '0, req_ready, acc;
  logic [19:0] req_ra1 = '0, req_ra2 = '0, req_wa = '0;
  logic [127:0] req_wdata = '0;
  logic rf_wr, rsp_valid, lock_abort;
  logic [4:0] rf_R1, rf_R2, rf_Rw;
  logic [31:0] rf_Din, rf_OUT1, rf_OUT2, rsp_d1, rsp_d2;
  logic [1:0] rsp_id;
  logic [31:0] rf_mem [32] = '{default: '0};
  logic [31:0] m_regs [32] = '{default: '0};
  bit m_locked, m_rv, m_abort;
  int m_owner, m_ptr, m_idle, m_rid;
  logic [31:0] m_d1, m_d2;
  int vectors = 0, errors = 0;
  regfile_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_lock(req_lock), .req_ra1(req_ra1), .req_ra2(req_ra2),
    .req_wa(req_wa), .req_wdata(req_wdata), .rf_wr(rf_wr), .rf_R1(rf_R1),
    .rf_R2(rf_R2), .rf_Rw(rf_Rw), .rf_Din(rf_Din), .rf_OUT1(rf_OUT1),
    .rf_OUT2(rf_OUT2), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_d1(rsp_d1),
    .rsp_d2(rsp_d2), .lock_abort(lock_abort)
  );
  // register file with registered outputs
  always @(posedge clk) begin
    if (rf_wr) rf_mem[rf_Rw] <= rf_Din;
    rf_OUT1 <= rf_mem[rf_R1];
    rf_OUT2 <= rf_mem[rf_R2];
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin : model
    int eg, j;
    logic [4:0] a1, a2, wa;
    logic [31:0] wd;
    bit w, l;
    if (!rst_n) begin
      m_locked = 0; m_ptr = 0; m_owner = 0; m_idle = 0; m_rv = 0; m_abort = 0;
      chk("rst_ready", req_ready, 0);
      chk("rst_rf_wr", rf_wr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_abort", lock_abort, 0);
    end else begin
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("rsp_id", rsp_id, m_rid);
        chk("rsp_d1", rsp_d1, m_d1);
        chk("rsp_d2", rsp_d2, m_d2);
      end
      chk("lock_abort", lock_abort, m_abort);
      eg = -1;
      if (m_locked) begin
        if (req_valid[m_owner]) eg = m_owner;
      end else begin
`ifdef RFARB_WRPRIO_EN
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (eg < 0 && req_valid[j] && req_wr[j]) eg = j;
        end
`endif
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (eg < 0 && req_valid[j]) eg = j;
        end
      end
      chk("ready", req_ready, (eg < 0) ? 32'd0 : 32'd1 << eg);
      m_rv = 0;
      m_abort = 0;
      if (eg < 0) begin
        chk("idle_rf_wr", rf_wr, 0);
        chk("idle_R1", rf_R1, 0);
        chk("idle_R2", rf_R2, 0);
        chk("idle_Rw", rf_Rw, 0);
        chk("idle_Din", rf_Din, 0);
        if (m_locked) begin
          m_idle++;
          if (m_idle == 15) begin
            m_locked = 0;
            m_abort = 1;
            m_ptr = (m_owner + 1) % 4;
          end
        end
      end else begin
        w = req_wr[eg]; l = req_lock[eg];
        a1 = req_ra1[eg*5 +: 5]; a2 = req_ra2[eg*5 +: 5]; wa = req_wa[eg*5 +: 5];
        wd = req_wdata[eg*32 +: 32];
        if (w) begin
          chk("wr_en", rf_wr, wa != 0);
          chk("wr_Rw", rf_Rw, wa);
          chk("wr_Din", rf_Din, wd);
          if (wa != 0) m_regs[wa] = wd;
        end else begin
          chk("rd_wr", rf_wr, 0);
          chk("rd_R1", rf_R1, a1);
          chk("rd_R2", rf_R2, a2);
          m_rv = 1; m_rid = eg; m_d1 = m_regs[a1]; m_d2 = m_regs[a2];
        end
        if (!m_locked) m_ptr = (eg + 1) % 4;
        m_locked = l; m_owner = eg; m_idle = 0;
      end
    end
  end
  task automatic set_req(int i, bit w, bit l, logic [4:0] a1, logic [4:0] a2, logic [4:0] wa, logic [31:0] d);
    req_valid[i] = 1'b1; req_wr[i] = w; req_lock[i] = l;
    req_ra1[i*5 +: 5] = a1; req_ra2[i*5 +: 5] = a2; req_wa[i*5 +: 5] = wa; req_wdata[i*32 +: 32] = d;
  endtask
  // called at a negedge: accepted requesters drop valid after the edge
  task automatic fin();
    acc = req_ready;
    @(posedge clk);
    #1 req_valid = req_valid & ~acc;
  endtask
  task automatic cyc();
    @(negedge clk);
    fin();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 0, 0, 5'(i), 5'(i + 1), 5'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_grant", req_ready, 32'd1 << c);
      if (c > 0) chk("t1_rsp_id", rsp_id, 32'(c - 1));
      fin();
    end
    @(negedge clk);
    chk("t1_rsp_last", {rsp_valid, rsp_id}, 3'b111);
    fin();
    set_req(1, 1, 0, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
    cyc();
    set_req(2, 0, 0, 5'd5, 5'd0, 5'd0, 32'd0);
    cyc();
    @(negedge clk);
    chk("t2_rsp", {rsp_valid, rsp_id}, 3'b110);
    chk("t2_d1", rsp_d1, 32'hDEADBEEF);
    chk("t2_d2", rsp_d2, 32'd0);
    fin();
    set_req(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("t3_ready", req_ready, 4'b0001);
    chk("t3_rf_wr", rf_wr, 0);
    fin();
    set_req(0, 0, 0, 5'd0, 5'd5, 5'd0, 32'd0);
    cyc();
    @(negedge clk);
    chk("t3_d1", rsp_d1, 32'd0);
    chk("t3_d2", rsp_d2, 32'hDEADBEEF);
    fin();
    set_req(3, 0, 1, 5'd1, 5'd2, 5'd0, 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) set_req(i, 0, 0, 5'(i), 5'(i), 5'd0, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold", req_ready, 0);
      fin();
    end
    set_req(3, 1, 0, 5'd0, 5'd0, 5'd7, 32'h12345678);
    @(negedge clk);
    chk("t4_owner", req_ready, 4'b1000);
    fin();
    @(negedge clk);
    chk("t4_resume", req_ready, 4'b0001);
    fin();
    cyc();
    cyc();
    set_req(1, 0, 1, 5'd3, 5'd4, 5'd0, 32'd0);
    cyc();
    set_req(2, 0, 0, 5'd7, 5'd5, 5'd0, 32'd0);
    repeat (15) begin
      @(negedge clk);
      chk("t5_hold", req_ready, 0);
      chk("t5_no_abort", lock_abort, 0);
      fin();
    end
    @(negedge clk);
    chk("t5_abort", lock_abort, 1);
    chk("t5_grant", req_ready, 4'b0100);
    fin();
    @(negedge clk);
    chk("t5_abort_pulse", lock_abort, 0);
    chk("t5_rsp", {rsp_valid, rsp_id}, 3'b110);
    chk("t5_d1", rsp_d1, 32'h12345678);
    fin();
    set_req(3, 0, 0, 5'd7, 5'd0, 5'd0, 32'd0);
    cyc();
    rst_n = 1'b0;
    set_req(1, 0, 0, 5'd5, 5'd7, 5'd0, 32'd0);
    set_req(2, 0, 0, 5'd7, 5'd5, 5'd0, 32'd0);
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_rf_wr", rf_wr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_grant", req_ready, 4'b0010);
    fin();
    cyc();
    set_req(3, 0, 0, 5'd1, 5'd2, 5'd0, 32'd0);
    cyc();
    set_req(0, 0, 0, 5'd1, 5'd2, 5'd0, 32'd0);
    set_req(3, 1, 0, 5'd0, 5'd0, 5'd9, 32'hA5A50009);
    @(negedge clk);
`ifdef RFARB_WRPRIO_EN
    chk("wrprio_grant", req_ready, 4'b1000);
`else
    chk("rr_grant", req_ready, 4'b0001);
`endif
    fin();
    cyc();
    cyc();
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i])
          set_req(i, (n + i) % 3 == 0, 0, 5'((n + i) % 10), 5'((n * 3 + i) % 10), 5'((n + 2 * i) % 10), 32'(n * 1000 + i));
      cyc();
    end
    req_valid = '0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
